// File: rtl/ahb_cmd_master.sv
// Single-outstanding AHB-Lite master: turns a valid/ready command into one
// NONSEQ single transfer and returns a one-cycle completion pulse.
module ahb_cmd_master #(
   parameter int         AWIDTH    = 32,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [AWIDTH-1:0] CMD_ADDR,
   input  logic [1:0]        CMD_SIZE,
   input  logic [31:0]       CMD_WDATA,
   output logic              RSP_VALID,
   output logic [31:0]       RSP_RDATA,
   output logic              RSP_ERROR,
   output logic [AWIDTH-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic              HMASTLOCK,
   output logic [3:0]        HPROT,
   output logic [31:0]       HWDATA,
   input  logic [31:0]       HRDATA,
   input  logic              HREADY,
   input  logic              HRESP
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   logic [1:0]        state;
   logic [AWIDTH-1:0] addr_q;
   logic              write_q;
   logic [1:0]        size_q;
   logic [31:0]       wdata_q;
   logic              rsp_valid_q;
   logic              rsp_error_q;
   logic [31:0]       rsp_rdata_q;

   logic              cmd_illegal;
   logic [7:0]        rd_byte;
   logic [31:0]       rd_extract;
   logic [31:0]       wdata_rep;

   // NOTE: every variable gets a default first so no path through the block infers a latch.
   always_comb begin
      cmd_illegal = 1'b0;
      case (CMD_SIZE)
         2'd1:    cmd_illegal = CMD_ADDR[0];
         2'd2:    cmd_illegal = (CMD_ADDR[1:0] != 2'b00);
         2'd3:    cmd_illegal = 1'b1;
         default: cmd_illegal = 1'b0;
      endcase
   end

   // Read lane selection uses the address still held on HADDR during the data phase.
   always_comb begin
      rd_byte = HRDATA[7:0];
      case (addr_q[1:0])
         2'd1:    rd_byte = HRDATA[15:8];
         2'd2:    rd_byte = HRDATA[23:16];
         2'd3:    rd_byte = HRDATA[31:24];
         default: rd_byte = HRDATA[7:0];
      endcase

      rd_extract = HRDATA;
      case (size_q)
         2'd0:    rd_extract = {24'd0, rd_byte};
         2'd1:    rd_extract = addr_q[1] ? {16'd0, HRDATA[31:16]} : {16'd0, HRDATA[15:0]};
         default: rd_extract = HRDATA;
      endcase
   end

   always_comb begin
      wdata_rep = wdata_q;
      case (size_q)
         2'd0:    wdata_rep = {4{wdata_q[7:0]}};
         2'd1:    wdata_rep = {2{wdata_q[15:0]}};
         default: wdata_rep = wdata_q;
      endcase
   end

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         write_q     <= 1'b0;
         size_q      <= 2'd0;
         wdata_q     <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         case (state)
            ST_IDLE: begin
               if (CMD_VALID) begin
                  if (cmd_illegal) begin
                     // Rejected without touching the bus, so the address/control registers keep their old values.
                     state       <= ST_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_error_q <= 1'b1;
                  end else begin
                     state   <= ST_ADDR;
                     addr_q  <= CMD_ADDR;
                     write_q <= CMD_WRITE;
                     size_q  <= CMD_SIZE;
                     wdata_q <= CMD_WDATA;
                  end
               end
            end
            ST_ADDR: begin
               if (HREADY) state <= ST_DATA;
            end
            ST_DATA: begin
               // An ERROR cycle with HREADY low is only the first half of the two-cycle response.
               if (HREADY) begin
                  state       <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_error_q <= HRESP;
                  rsp_rdata_q <= write_q ? 32'd0 : rd_extract;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign CMD_READY = (state == ST_IDLE);
   assign RSP_VALID = rsp_valid_q;
   assign RSP_ERROR = rsp_error_q;
   assign RSP_RDATA = rsp_rdata_q;

   assign HTRANS    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR     = addr_q;
   assign HWRITE    = write_q;
   assign HSIZE     = {1'b0, size_q};
   assign HWDATA    = (state == ST_DATA && write_q) ? wdata_rep : 32'd0;
   assign HBURST    = 3'b000;
   assign HMASTLOCK = 1'b0;
   assign HPROT     = HPROT_VAL;

endmodule
